// File: rtl/analysis_frame_ctrl.sv
`timescale 1ns/1ps
// Purpose: gathers 16 serial FFT bins into a frame buffer, launches the analysis unit and returns its answer.
// Latency: frame_valid 1 cycle after the 16th beat; res_valid 1 cycle after ana_done.
// Backpressure: in_ready low while a frame is in flight; res_valid/res_freq held until res_ready.
//
// Build option: FRAME_PINGPONG_EN adds a second frame bank. The next frame fills while the current one is
// analysed, and in_ready only drops when that spare bank is full and waiting for launch.
//
// Ports:
//   CLK, RST                         clock (rising edge), asynchronous active-high reset
//   in_valid, in_data, in_ready      bin words, bins 0..15 in order, {real[31:16], imag[15:0]}
//   frame_bus, frame_valid           parallel frame (bin k on [32k+31:32k]) and one-cycle launch strobe
//   ana_done, ana_freq               analysis unit response
//   res_valid, res_freq, res_ready   dominant bin index result, valid/ready
//   frame_cnt                        completed result handshakes, wraps
//   err_timeout                      sticky, set when a frame is dropped for lack of ana_done
module analysis_frame_ctrl #(
    parameter int TIMEOUT_CYC = 8,
    parameter int CNT_W       = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             in_valid,
    input  logic [31:0]      in_data,
    output logic             in_ready,
    output logic [511:0]     frame_bus,
    output logic             frame_valid,
    input  logic             ana_done,
    input  logic [3:0]       ana_freq,
    output logic             res_valid,
    output logic [3:0]       res_freq,
    input  logic             res_ready,
    output logic [CNT_W-1:0] frame_cnt,
    output logic             err_timeout
);

    typedef enum logic [1:0] {S_FILL, S_LAUNCH, S_WAIT, S_RESULT} state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);

    state_t           state_q;
    logic [7:0]       timer_q;
    logic             frame_valid_q;
    logic             res_valid_q;
    logic             err_timeout_q;
    logic [3:0]       res_freq_q;
    logic [CNT_W-1:0] frame_cnt_q;

    logic       beat;
    logic       beat_last;
    logic       relaunch;   // on leaving WAIT/RESULT, a complete frame is already waiting
    logic [3:0] wr_cnt;     // beat index within the bank currently being written

    assign beat      = in_valid & in_ready;
    assign beat_last = beat && (wr_cnt == 4'd15);

`ifdef FRAME_PINGPONG_EN
    logic [511:0] bank_q [2];
    logic [3:0]   cnt_q  [2];
    logic         cur_q;        // bank being filled in FILL, launched/analysed otherwise
    logic         alt_full_q;   // spare bank complete, not yet launched
    logic         alt_full_d;
    logic         wr_bank;
    logic         leave;

    assign wr_bank    = (state_q == S_FILL) ? cur_q : ~cur_q;
    assign wr_cnt     = cnt_q[wr_bank];
    assign in_ready   = (state_q == S_FILL) || !alt_full_q;
    // A beat completing the spare bank in the very cycle we leave must still trigger the relaunch.
    assign alt_full_d = alt_full_q || (beat_last && (state_q != S_FILL));
    assign leave      = ((state_q == S_WAIT) && !ana_done && (timer_q == TMO_LAST)) ||
                        ((state_q == S_RESULT) && res_ready);
    assign relaunch   = alt_full_d;
    assign frame_bus  = bank_q[cur_q];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            bank_q[0]  <= '0;
            bank_q[1]  <= '0;
            cnt_q[0]   <= '0;
            cnt_q[1]   <= '0;
            cur_q      <= 1'b0;
            alt_full_q <= 1'b0;
        end else begin
            if (beat) begin
                bank_q[wr_bank][{wr_cnt, 5'd0} +: 32] <= in_data;
                cnt_q[wr_bank]                        <= wr_cnt + 4'd1;  // wraps to 0 after bin 15
            end
            // Always swap on leave: either the full spare is launched next, or filling resumes
            // in the spare at whatever count it reached.
            if (leave) begin
                cur_q      <= ~cur_q;
                alt_full_q <= 1'b0;
            end else begin
                alt_full_q <= alt_full_d;
            end
        end
    end
`else
    logic [511:0] bank_q;
    logic [3:0]   cnt_q;

    assign wr_cnt    = cnt_q;
    assign in_ready  = (state_q == S_FILL);
    assign relaunch  = 1'b0;
    assign frame_bus = bank_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            bank_q <= '0;
            cnt_q  <= '0;
        end else if (beat) begin
            bank_q[{cnt_q, 5'd0} +: 32] <= in_data;
            cnt_q                       <= cnt_q + 4'd1;  // wraps to 0 after bin 15
        end
    end
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q       <= S_FILL;
            timer_q       <= '0;
            frame_valid_q <= 1'b0;
            res_valid_q   <= 1'b0;
            res_freq_q    <= '0;
            frame_cnt_q   <= '0;
            err_timeout_q <= 1'b0;
        end else begin
            frame_valid_q <= 1'b0;
            case (state_q)
                S_FILL: begin
                    if (beat_last) begin
                        state_q       <= S_LAUNCH;
                        frame_valid_q <= 1'b1;
                    end
                end
                S_LAUNCH: begin
                    timer_q <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    timer_q <= timer_q + 8'd1;
                    // A response on the last allowed cycle still counts.
                    if (ana_done) begin
                        res_freq_q  <= ana_freq;
                        res_valid_q <= 1'b1;
                        state_q     <= S_RESULT;
                    end else if (timer_q == TMO_LAST) begin
                        err_timeout_q <= 1'b1;
                        state_q       <= relaunch ? S_LAUNCH : S_FILL;
                        frame_valid_q <= relaunch;
                    end
                end
                S_RESULT: begin
                    if (res_ready) begin
                        res_valid_q   <= 1'b0;
                        frame_cnt_q   <= frame_cnt_q + CNT_W'(1);
                        state_q       <= relaunch ? S_LAUNCH : S_FILL;
                        frame_valid_q <= relaunch;
                    end
                end
                default: state_q <= S_FILL;
            endcase
        end
    end

    assign frame_valid = frame_valid_q;
    assign res_valid   = res_valid_q;
    assign res_freq    = res_freq_q;
    assign frame_cnt   = frame_cnt_q;
    assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_analysis_frame_ctrl.sv
`timescale 1ns/1ps
module tb_analysis_frame_ctrl;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         in_valid = 1'b0;
    logic [31:0]  in_data = '0;
    logic         in_ready;
    logic [511:0] frame_bus;
    logic         frame_valid;
    logic         ana_done;
    logic [3:0]   ana_freq;
    logic         res_valid;
    logic [3:0]   res_freq;
    logic         res_ready = 1'b1;
    logic [3:0]   frame_cnt;
    logic         err_timeout;

    logic         model_done = 1'b0;
    logic         model_on   = 1'b1;
    logic [3:0]   model_freq = '0;
    logic         spur_done  = 1'b0;
    logic [3:0]   spur_freq  = '0;

    int n_pass  = 0;
    int n_total = 0;
    int exp_cnt = 0;
    int fv_seen = 0;

    logic [511:0] exp_frm[$];
    logic [3:0]   exp_res[$];

    assign ana_done = model_done | spur_done;
    assign ana_freq = spur_done ? spur_freq : model_freq;

    analysis_frame_ctrl #(.TIMEOUT_CYC(8), .CNT_W(4)) dut (
        .CLK(CLK), .RST(RST),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .frame_bus(frame_bus), .frame_valid(frame_valid),
        .ana_done(ana_done), .ana_freq(ana_freq),
        .res_valid(res_valid), .res_freq(res_freq), .res_ready(res_ready),
        .frame_cnt(frame_cnt), .err_timeout(err_timeout)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic check_frame(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Non-dominant bins are small; the dominant bin has magnitude 256 (sign chosen by salt).
    function automatic logic [31:0] bin_word(input int k, input int dom, input int salt);
        logic [15:0] re;
        logic [15:0] im;
        if (k == dom) begin
            re = salt[0] ? 16'hff00 : 16'h0100;
            im = 16'h0000;
        end else begin
            re = 16'(k + salt);
            im = salt[1] ? 16'(-k) : 16'(k);
        end
        return {re, im};
    endfunction

    function automatic logic [511:0] build_frame(input int dom, input int salt);
        logic [511:0] f;
        for (int k = 0; k < 16; k++) f[32*k +: 32] = bin_word(k, dom, salt);
        return f;
    endfunction

    // Analysis unit model: largest |bin|^2, lowest index on ties.
    function automatic logic [3:0] argmax(input logic [511:0] fb);
        int         best;
        logic [3:0] idx;
        best = -1;
        idx  = '0;
        for (int k = 0; k < 16; k++) begin
            logic signed [15:0] re;
            logic signed [15:0] im;
            int m;
            re = fb[32*k+16 +: 16];
            im = fb[32*k +: 16];
            m  = int'(re) * int'(re) + int'(im) * int'(im);
            if (m > best) begin
                best = m;
                idx  = 4'(k);
            end
        end
        return idx;
    endfunction

    initial begin : ana_model
        logic [3:0] f;
        forever begin
            @(negedge CLK);
            if (frame_valid && model_on) begin
                f = argmax(frame_bus);
                repeat (3) @(posedge CLK);
                #1 model_freq = f;
                model_done = 1'b1;
                @(posedge CLK);
                #1 model_done = 1'b0;
            end
        end
    end

    initial begin : monitor
        forever begin
            @(negedge CLK);
            #1;
            if (frame_valid) begin
                fv_seen++;
                if (exp_frm.size() == 0) begin
                    n_total++;
                    $display("FAIL frame_unexpected: frame_valid=1 with bus %0h, no frame expected", frame_bus);
                end else begin
                    check_frame("frame_bus", frame_bus, exp_frm.pop_front());
                end
            end
            if (res_valid && res_ready) begin
                if (exp_res.size() == 0) begin
                    n_total++;
                    $display("FAIL res_unexpected: res_freq=%0d presented, no result expected", res_freq);
                end else begin
                    check("res_freq", int'(res_freq), int'(exp_res.pop_front()));
                end
            end
        end
    end

    task automatic send_beat(input logic [31:0] d);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && n < 100) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 100) begin
            n_total++;
            $display("FAIL in_ready_wait: in_ready=0 for 100 cycles, required 1");
        end
        @(negedge CLK);
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input int dom, input int salt, input bit want_res);
        logic [511:0] f;
        f = build_frame(dom, salt);
        exp_frm.push_back(f);
        if (want_res) begin
            exp_res.push_back(4'(dom));
            exp_cnt++;
        end
        for (int k = 0; k < 16; k++) send_beat(f[32*k +: 32]);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_res.size() != 0 || exp_frm.size() != 0) && n < 300) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 300) begin
            n_total++;
            $display("FAIL drain: %0d results and %0d frames pending, required 0", exp_res.size(), exp_frm.size());
        end
        @(negedge CLK);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int           fv0;
        int           n;
        logic [511:0] f;

        repeat (3) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);

        // Reset state
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_frame_valid", int'(frame_valid), 0);
        check("rst_res_valid", int'(res_valid), 0);
        check("rst_res_freq", int'(res_freq), 0);
        check("rst_frame_cnt", int'(frame_cnt), 0);
        check("rst_err_timeout", int'(err_timeout), 0);
        check_frame("rst_frame_bus", frame_bus, '0);

        // Single frame, bin 9 dominant; returns at negedge of cycle N+1
        send_frame(9, 0, 1);
        check("lat_frame_valid", int'(frame_valid), 1);
        repeat (3) @(negedge CLK);
        check("lat_res_early", int'(res_valid), 0);
        @(negedge CLK);
        check("lat_res_valid", int'(res_valid), 1);
        check("lat_res_freq", int'(res_freq), 9);
        @(negedge CLK);
        check("lat_next_ready", int'(in_ready), 1);
        check("lat_res_cleared", int'(res_valid), 0);
        wait_drain();
        check("single_cnt", int'(frame_cnt), exp_cnt % 16);

        // Result backpressure
        res_ready = 1'b0;
        send_frame(5, 3, 1);
        n = 0;
        while (!res_valid && n < 20) begin
            @(negedge CLK);
            n++;
        end
        check("bp_res_valid_seen", int'(res_valid), 1);
`ifdef FRAME_PINGPONG_EN
        send_frame(11, 9, 1);
        check("bp_res_hold", int'(res_valid), 1);
        check("bp_freq_hold", int'(res_freq), 5);
        check("bp_spare_full", int'(in_ready), 0);
        res_ready = 1'b1;
        @(negedge CLK);
        check("pp_launch_after_hs", int'(frame_valid), 1);
`else
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            check("bp_res_hold", int'(res_valid), 1);
            check("bp_freq_hold", int'(res_freq), 5);
            check("bp_in_ready", int'(in_ready), 0);
        end
        res_ready = 1'b1;
`endif
        wait_drain();
        check("bp_cnt", int'(frame_cnt), exp_cnt % 16);

        // Timeout: unit never answers
        model_on = 1'b0;
        send_frame(2, 11, 0);
        repeat (8) @(negedge CLK);
        check("to_err_early", int'(err_timeout), 0);
        @(negedge CLK);
        check("to_err_set", int'(err_timeout), 1);
        check("to_no_res", int'(res_valid), 0);
        check("to_in_ready", int'(in_ready), 1);
        check("to_cnt", int'(frame_cnt), exp_cnt % 16);
        model_on = 1'b1;
        send_frame(12, 20, 1);
        wait_drain();
        check("to_err_sticky", int'(err_timeout), 1);
        check("to_next_cnt", int'(frame_cnt), exp_cnt % 16);

        // Reset mid-frame: 7 stale beats with a huge bin 0
        for (int k = 0; k < 7; k++) send_beat(bin_word(k, 0, 30));
        RST = 1'b1;
        @(negedge CLK);
        check("rstmid_in_ready", int'(in_ready), 1);
        check("rstmid_err", int'(err_timeout), 0);
        check("rstmid_cnt", int'(frame_cnt), 0);
        check_frame("rstmid_bus", frame_bus, '0);
        RST = 1'b0;
        exp_cnt = 0;
        @(negedge CLK);
        send_frame(3, 1, 1);
        wait_drain();
        check("rstmid_after_cnt", int'(frame_cnt), 1);

        // Gapped input with a spurious ana_done while filling
        fv0 = fv_seen;
        f = build_frame(14, 6);
        exp_frm.push_back(f);
        exp_res.push_back(4'd14);
        exp_cnt++;
        for (int k = 0; k < 16; k++) begin
            send_beat(f[32*k +: 32]);
            if (k < 15) begin
                if (k == 5) begin
                    spur_freq = 4'd15;
                    spur_done = 1'b1;
                end
                @(negedge CLK);
                spur_done = 1'b0;
            end
        end
        check("gap_frame_valid", int'(frame_valid), 1);
        wait_drain();
        check("gap_one_launch", fv_seen - fv0, 1);
        check("gap_cnt", int'(frame_cnt), exp_cnt % 16);

        // Counter wrap with CNT_W=4: 17 frames after reset
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        exp_cnt = 0;
        @(negedge CLK);
        for (int i = 0; i < 17; i++) send_frame(i % 16, i, 1);
        wait_drain();
        check("wrap_cnt", int'(frame_cnt), 1);
        check("end_frames_left", exp_frm.size(), 0);
        check("end_results_left", exp_res.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
